// File: rtl/ad_data_tx_pkg.sv
// ad_data_tx_pkg: shared constants and types for the AD sample transmit packer.
//   Line words (IDLE/FILL/SOF/DATA) with their K-flag masks, the 8b/10b
//   K-characters used in them, and the framing state enum.
package ad_data_tx_pkg;

   localparam logic [7:0]  K28_5     = 8'hBC;
   localparam logic [7:0]  K28_1     = 8'h3C;
   localparam logic [7:0]  K28_0     = 8'h1C;

   localparam logic [31:0] IDLE_WORD = 32'h5050_50BC;
   localparam logic [3:0]  IDLE_K    = 4'b0001;
   localparam logic [31:0] FILL_WORD = {24'h00_0000, K28_0};
   localparam logic [3:0]  FILL_K    = 4'b0001;
   localparam logic [3:0]  SOF_K     = 4'b0011;
   localparam logic [3:0]  DATA_K    = 4'b0000;

   typedef enum logic [1:0] {IDLE, SOF, DATA} tx_state_t;

   // Header word: sequence number, payload length, then the two K-characters.
   function automatic logic [31:0] sof_word(input logic [7:0] seq, input logic [7:0] len);
      return {seq, len, K28_1, K28_5};
   endfunction

endpackage

// File: rtl/ad_data_tx_pack_asm.sv
// ad_byte_asm: 8-to-32 little-endian assembler on the FIFO read port.
//   i_clk/i_rst       : FIFO read clock, synchronous active-high reset
//   i_fifo_rd_empty   : FIFO empty flag
//   i_fifo_rd_data    : FIFO data, valid the cycle after o_fifo_rd_en
//   i_stg_take        : staging word is consumed this cycle
//   o_fifo_rd_en      : FIFO read enable
//   o_stg_word/valid  : completed 32-bit word waiting for the framer
module ad_byte_asm (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_fifo_rd_empty,
   input  logic [7:0]  i_fifo_rd_data,
   input  logic        i_stg_take,
   output logic        o_fifo_rd_en,
   output logic [31:0] o_stg_word,
   output logic        o_stg_valid
);

   logic [2:0][7:0] r_asm;
   logic [1:0]      r_asm_cnt;
   logic            r_rd_pend;
   logic [31:0]     r_stg;
   logic            r_stg_valid;

   logic [2:0]      w_held;
   logic            w_last;

   // Bytes already committed to the assembler, counting the one in flight.
   assign w_held = {1'b0, r_asm_cnt} + {2'b00, r_rd_pend};
   assign w_last = r_rd_pend && (r_asm_cnt == 2'd3);

   // A read may complete a word only if staging is free by the time it lands;
   // otherwise keep reading only while the assembler still has a free lane.
   // Gated by reset so the FIFO is never popped while the block is held.
   assign o_fifo_rd_en = !i_rst && !i_fifo_rd_empty &&
                         (!r_stg_valid || i_stg_take || (w_held < 3'd3));

   assign o_stg_word  = r_stg;
   assign o_stg_valid = r_stg_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_asm       <= '0;
         r_asm_cnt   <= 2'd0;
         r_rd_pend   <= 1'b0;
         r_stg       <= '0;
         r_stg_valid <= 1'b0;
      end else begin
         r_rd_pend <= o_fifo_rd_en;
         if (r_rd_pend) begin
            r_asm_cnt <= r_asm_cnt + 2'd1;
            case (r_asm_cnt)
               2'd0:    r_asm[0] <= i_fifo_rd_data;
               2'd1:    r_asm[1] <= i_fifo_rd_data;
               2'd2:    r_asm[2] <= i_fifo_rd_data;
               default: r_stg    <= {i_fifo_rd_data, r_asm[2], r_asm[1], r_asm[0]};
            endcase
         end
         if (w_last)
            r_stg_valid <= 1'b1;
         else if (i_stg_take)
            r_stg_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ad_data_tx_pack.sv
// ad_data_tx_pack: drains the AD sample FIFO and frames 32-bit words into
// fixed-length packets for the HSST transmit lane, one word per cycle.
//   i_rd_clk/i_rd_rst : FIFO read clock, synchronous active-high reset
//   i_tx_en           : permits a new packet to start (looked at in IDLE only)
//   o_fifo_rd_en, i_fifo_rd_data, i_fifo_rd_empty : FIFO read port
//   o_txdata/o_txcharisk : registered lane word and per-byte K flags
//   o_pkt_seq         : sequence number of the current or next packet
//   o_fill_cnt        : saturating count of fill words sent
//   o_busy            : packet in progress (SOF or DATA)
module ad_data_tx_pack
   import ad_data_tx_pkg::*;
#(
   parameter int PKT_WORDS = 64,
   parameter int IDLE_MIN  = 2
) (
   input  logic        i_rd_clk,
   input  logic        i_rd_rst,
   input  logic        i_tx_en,
   output logic        o_fifo_rd_en,
   input  logic [7:0]  i_fifo_rd_data,
   input  logic        i_fifo_rd_empty,
   output logic [31:0] o_txdata,
   output logic [3:0]  o_txcharisk,
   output logic [7:0]  o_pkt_seq,
   output logic [15:0] o_fill_cnt,
   output logic        o_busy
);

   localparam logic [7:0] PKT_LEN   = 8'(PKT_WORDS);
   localparam logic [7:0] LAST_WORD = 8'(PKT_WORDS - 1);
   localparam logic [3:0] GAP_MIN   = 4'(IDLE_MIN);

   tx_state_t   r_state;
   logic [3:0]  r_gap_cnt;
   logic [7:0]  r_word_cnt;
   logic [7:0]  r_pkt_seq;
   logic [15:0] r_fill_cnt;
   logic [31:0] r_txdata;
   logic [3:0]  r_txcharisk;
   logic        r_busy;

   logic        w_stg_take;
   logic        w_stg_valid;
   logic [31:0] w_stg_word;
   logic [3:0]  w_gap_nxt;

   ad_byte_asm u_asm (
      .i_clk           (i_rd_clk),
      .i_rst           (i_rd_rst),
      .i_fifo_rd_empty (i_fifo_rd_empty),
      .i_fifo_rd_data  (i_fifo_rd_data),
      .i_stg_take      (w_stg_take),
      .o_fifo_rd_en    (o_fifo_rd_en),
      .o_stg_word      (w_stg_word),
      .o_stg_valid     (w_stg_valid)
   );

   assign w_stg_take = (r_state == DATA) && w_stg_valid;

   // Idle words sent so far including the one going out this cycle, so the
   // gap between packets is exactly IDLE_MIN words when data is waiting.
   assign w_gap_nxt = (r_gap_cnt == 4'hF) ? 4'hF : r_gap_cnt + 4'd1;

   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst) begin
         r_state     <= IDLE;
         r_gap_cnt   <= GAP_MIN;
         r_word_cnt  <= 8'd0;
         r_pkt_seq   <= 8'd0;
         r_fill_cnt  <= 16'd0;
         r_txdata    <= IDLE_WORD;
         r_txcharisk <= IDLE_K;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_txdata    <= IDLE_WORD;
               r_txcharisk <= IDLE_K;
               r_gap_cnt   <= w_gap_nxt;
               if (i_tx_en && w_stg_valid && (w_gap_nxt >= GAP_MIN)) begin
                  r_state <= SOF;
                  r_busy  <= 1'b1;
               end
            end
            SOF: begin
               r_txdata    <= sof_word(r_pkt_seq, PKT_LEN);
               r_txcharisk <= SOF_K;
               r_word_cnt  <= 8'd0;
               r_state     <= DATA;
            end
            DATA: begin
               if (w_stg_valid) begin
                  r_txdata    <= w_stg_word;
                  r_txcharisk <= DATA_K;
                  r_word_cnt  <= r_word_cnt + 8'd1;
                  if (r_word_cnt == LAST_WORD) begin
                     r_state   <= IDLE;
                     r_busy    <= 1'b0;
                     r_pkt_seq <= r_pkt_seq + 8'd1;
                     r_gap_cnt <= 4'd0;
                  end
               end else begin
                  r_txdata    <= FILL_WORD;
                  r_txcharisk <= FILL_K;
                  if (r_fill_cnt != 16'hFFFF)
                     r_fill_cnt <= r_fill_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_txdata    = r_txdata;
   assign o_txcharisk = r_txcharisk;
   assign o_pkt_seq   = r_pkt_seq;
   assign o_fill_cnt  = r_fill_cnt;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_ad_data_tx_pack.sv
module tb_ad_data_tx_pack;
   import ad_data_tx_pkg::*;

   localparam int PKT_WORDS = 4;
   localparam int IDLE_MIN  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_en = 1'b0;
   logic        rd_en;
   logic        rd_empty = 1'b1;
   logic [7:0]  rd_data = 8'h00;
   logic [31:0] txdata;
   logic [3:0]  txk;
   logic [7:0]  pkt_seq;
   logic [15:0] fill_cnt;
   logic        busy;

   always #5 clk = ~clk;

   ad_data_tx_pack #(.PKT_WORDS(PKT_WORDS), .IDLE_MIN(IDLE_MIN)) dut (
      .i_rd_clk        (clk),
      .i_rd_rst        (rst),
      .i_tx_en         (tx_en),
      .o_fifo_rd_en    (rd_en),
      .i_fifo_rd_data  (rd_data),
      .i_fifo_rd_empty (rd_empty),
      .o_txdata        (txdata),
      .o_txcharisk     (txk),
      .o_pkt_seq       (pkt_seq),
      .o_fill_cnt      (fill_cnt),
      .o_busy          (busy)
   );

   logic [7:0]  fifo_q[$];
   logic [7:0]  sb_q[$];
   logic [31:0] exp_w;
   logic [7:0]  exp_seq = 8'h00;
   int n_vec = 0, n_err = 0;
   int popped = 0, consumed = 0;
   int dcnt = 0, idle_run = 0, fill_seen = 0, fills_at2 = 0, pkt_done = 0;
   bit in_pkt = 1'b0, chk_gap = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // FIFO model: no output register, data appears the cycle after the pop.
   always @(posedge clk) begin
      if (rd_en && fifo_q.size() > 0) begin
         rd_data <= fifo_q.pop_front();
         popped++;
      end
   end
   always @(negedge clk) rd_empty = (fifo_q.size() == 0);

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      sb_q.push_back(b);
      rd_empty = 1'b0;
   endtask

   // Lane monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (txk == SOF_K) begin
            chk("hdr", txdata, {exp_seq, 8'(PKT_WORDS), K28_1, K28_5});
            chk("hdr_in_pkt", 32'(in_pkt), 0);
            if (chk_gap) chk("gap_min", 32'(idle_run >= IDLE_MIN), 1);
            in_pkt = 1'b1;
            dcnt   = 0;
         end else if (txk == DATA_K) begin
            chk("data_in_pkt", 32'(in_pkt), 1);
            if (sb_q.size() < 4) chk("sb_underrun", 32'(sb_q.size()), 4);
            else begin
               exp_w = {sb_q[3], sb_q[2], sb_q[1], sb_q[0]};
               repeat (4) void'(sb_q.pop_front());
               consumed += 4;
               chk("data", txdata, exp_w);
            end
            dcnt++;
            if (dcnt == PKT_WORDS) begin
               in_pkt = 1'b0;
               exp_seq++;
               pkt_done++;
               idle_run = 0;
            end
         end else if (txk == FILL_K && txdata == FILL_WORD) begin
            chk("fill_in_pkt", 32'(in_pkt), 1);
            fill_seen++;
            if (dcnt == 2) fills_at2++;
         end else if (txk == IDLE_K && txdata == IDLE_WORD) begin
            chk("idle_in_pkt", 32'(in_pkt), 0);
            idle_run++;
         end else begin
            chk("bad_word", txdata, IDLE_WORD);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic wait_pkts(input int target, input int budget);
      int c = 0;
      while (pkt_done < target && c < budget) begin
         tick();
         c++;
      end
      chk("pkt_timeout", pkt_done, target);
   endtask

   task automatic wait_hdr(input int budget);
      int c = 0;
      while (!in_pkt && c < budget) begin
         tick();
         c++;
      end
      chk("hdr_timeout", 32'(in_pkt), 1);
   endtask

   initial begin
      int n_drop;
      int c;
      // reset with FIFO non-empty
      for (int i = 0; i < 16; i++) push(8'(i));
      tick(3);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_txdata", txdata, IDLE_WORD);
      chk("rst_txk", 32'(txk), 32'(IDLE_K));
      chk("rst_seq", 32'(pkt_seq), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fill", 32'(fill_cnt), 0);

      // single packet of bytes 0x00..0x0F
      rst = 1'b0;
      tx_en = 1'b1;
      wait_pkts(1, 100);
      tick(3);
      chk("p1_seq", 32'(pkt_seq), 1);
      chk("p1_busy", 32'(busy), 0);
      chk("p1_idle", txdata, IDLE_WORD);

      // starvation: 8 bytes, then 8 more 20 cycles later
      fills_at2 = 0;
      for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
      tick(20);
      for (int i = 8; i < 16; i++) push(8'(8'h20 + i));
      wait_pkts(2, 200);
      tick(2);
      chk("starve_fills", 32'(fills_at2 >= 8), 1);
      chk("fill_cnt", 32'(fill_cnt), fill_seen);

      // tx_en dropped after SOF, then backpressure with bytes left over
      for (int i = 0; i < 24; i++) push(8'(8'h40 + i));
      wait_hdr(100);
      tx_en = 1'b0;
      wait_pkts(3, 200);
      tick(30);
      chk("bp_held", popped - consumed, 7);
      chk("bp_rd_en", 32'(rd_en), 0);
      chk("bp_fifo", 32'(fifo_q.size()), 1);
      chk("bp_seq", 32'(pkt_seq), 3);
      chk("bp_busy", 32'(busy), 0);
      chk("bp_no_pkt", 32'(in_pkt), 0);

      // back-to-back through the sequence wrap (seq 3 .. 0x00)
      for (int i = 0; i < 4056; i++) push(8'(i * 7 + 1));
      chk_gap = 1'b1;
      tx_en = 1'b1;
      wait_pkts(257, 257 * 40);
      tick(2);
      chk_gap = 1'b0;
      chk("wrap_seq", 32'(pkt_seq), 1);
      chk("b2b_fill", 32'(fill_cnt), fill_seen);

      // reset after data word 2
      for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
      c = 0;
      while (!(in_pkt && dcnt == 2) && c < 200) begin
         tick();
         c++;
      end
      chk("mid_timeout", 32'(in_pkt && dcnt == 2), 1);
      rst = 1'b1;
      tick();
      chk("mid_txdata", txdata, IDLE_WORD);
      chk("mid_txk", 32'(txk), 32'(IDLE_K));
      chk("mid_seq", 32'(pkt_seq), 0);
      chk("mid_fill", 32'(fill_cnt), 0);
      chk("mid_busy", 32'(busy), 0);
      // bytes already pulled from the FIFO but not sent are discarded
      n_drop = popped - consumed;
      repeat (n_drop) void'(sb_q.pop_front());
      consumed = popped;
      in_pkt = 1'b0; dcnt = 0; exp_seq = 8'h00; fill_seen = 0; idle_run = 0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
      wait_hdr(100);
      tx_en = 1'b0;
      wait_pkts(pkt_done + 1, 200);
      tick(3);
      chk("post_seq", 32'(pkt_seq), 1);
      chk("post_fill", 32'(fill_cnt), fill_seen);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ad_data_tx_pack.md
Name: ad_data_tx_pack

Overview:
- Read-side consumer of the 8-bit asynchronous AD sample FIFO, running in the FIFO read clock domain.
- Drains bytes from the FIFO read port and assembles them into 32-bit little-endian words.
- Frames the words into fixed-length packets for the HSST transmit lane: a header word with K-characters, then payload words.
- When no payload word is ready it inserts fill words (inside a packet) or idle words (between packets), so the lane carries one word every cycle.

Parameters:
- PKT_WORDS, 64, payload words per packet (2..255).
- IDLE_MIN, 2, minimum idle words between packets (1..15).

Ports:
- rd_clk  in  1  block clock, also the FIFO read clock.
- rd_rst  in  1  reset, synchronous, active-high.
- tx_en  in  1  allows a new packet to start; sampled in IDLE only.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  8  FIFO read data; valid the cycle after fifo_rd_en (no output register).
- fifo_rd_empty  in  1  FIFO empty flag.
- txdata  out  32  HSST transmit word; byte0 is [7:0].
- txcharisk  out  4  per-byte K flag.
- pkt_seq  out  8  sequence number of the current or next packet.
- fill_cnt  out  16  count of fill words, saturating.
- busy  out  1  high in SOF or DATA state.

Behaviour:
- One clock, rd_clk. Reset is synchronous and active-high on rd_rst; every register clears on the rising edge with rd_rst high.
- Reset values:
  - txdata = IDLE_WORD (0x505050BC), txcharisk = 4'b0001.
  - fifo_rd_en = 0, pkt_seq = 0, fill_cnt = 0, busy = 0.
  - state = IDLE, gap_cnt = IDLE_MIN (a packet may start right after reset).
  - assembler count asm_cnt = 0, read-pending flag rd_pend = 0, staging-valid flag stg_valid = 0.
- Read path:
  - rd_pend <= fifo_rd_en.
  - A pending byte is shifted into the assembler at lane asm_cnt. The first byte read goes to [7:0].
  - When the 4th byte lands, the word moves to the staging register, stg_valid is set and asm_cnt wraps to 0.
  - fifo_rd_en = !fifo_rd_empty && (!stg_valid || stg_take || (asm_cnt + rd_pend) < 3). stg_take is high when the staging word is emitted this cycle.
  - Invariants: no byte is dropped or duplicated. With staging draining, the block sustains 1 byte per cycle. In IDLE, reads stall once staging is full and asm_cnt + rd_pend = 3.
- Output register: every cycle exactly one word is registered onto txdata/txcharisk, giving one cycle of latency from the state decision.
- State machine:
  - IDLE:
    - Emits IDLE_WORD.
    - gap_cnt increments, saturating at 15.
    - Goes to SOF when tx_en && stg_valid && gap_cnt >= IDLE_MIN.
  - SOF:
    - Emits {pkt_seq, PKT_WORDS[7:0], 0x3C, 0xBC} with txcharisk 4'b0011.
    - Goes to DATA; word_cnt = 0.
  - DATA:
    - If stg_valid: emits the staging word with txcharisk 4'b0000, asserts stg_take, increments word_cnt.
    - Else: emits FILL_WORD (0x0000001C, txcharisk 4'b0001) and increments fill_cnt, saturating at 0xFFFF.
    - After the PKT_WORDS-th data word: goes to IDLE, pkt_seq increments (wraps 0xFF to 0x00), gap_cnt = 0.
- tx_en deassert mid-packet has no effect; the current packet always completes with exactly PKT_WORDS data words.
- rd_rst mid-packet:
  - Aborts the packet immediately; the next cycle outputs IDLE_WORD.
  - Partially assembled bytes are discarded.
  - pkt_seq and fill_cnt clear.
- Receiver contract: any word with txcharisk != 0, other than SOF, carries no data.

Decomposition:
- Package ad_data_tx_pkg holds:
  - IDLE_WORD, FILL_WORD and their charisk values.
  - K28_5 = 0xBC, K28_1 = 0x3C, K28_0 = 0x1C.
  - The state enum {IDLE, SOF, DATA}.
- Sub-module ad_byte_asm: the 8-to-32 assembler with staging register and the read-enable rule. The framing FSM and output register stay in the top.

Test Plan:
- Reset: hold rd_rst 3 cycles with the FIFO non-empty -> fifo_rd_en = 0, txdata = 0x505050BC, txcharisk = 0001, pkt_seq = 0, busy = 0.
- Single packet: PKT_WORDS = 4, FIFO preloaded 0x00..0x0F, tx_en = 1 -> header 0x00043CBC/0011, then 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with charisk 0000, then idle; pkt_seq = 1.
- Starvation: write only 8 bytes, then 8 more 20 cycles later -> FILL_WORD 0x0000001C/0001 between data words 2 and 3; fill_cnt equals the number of fill cycles; no byte lost.
- Back-to-back: continuous FIFO data, IDLE_MIN = 2 -> exactly 2 idle words between packets; pkt_seq goes 0xFE, 0xFF, 0x00 over three packets.
- tx_en drop and backpressure: drop tx_en after SOF -> packet completes with 4 data words, then idle persists. With the FIFO full, fifo_rd_en stops after 7 bytes are held (4 in staging, 3 in the assembler).
- Mid-packet reset: assert rd_rst after data word 2 -> next word IDLE_WORD; after release, the next packet header carries seq 0x00 and starts on a fresh 4-byte boundary.
